l1_pmem_arbiter: RTL and testbench
==================================

Name: l1_pmem_arbiter

Overview:
- Sits directly downstream of the instruction and data L1 cache datapaths/controllers and upstream of the shared physical memory (or L2) port.
- Accepts 128-bit line read (fill) and write (write-back) requests from both L1s and serialises them onto the single memory port.
- Latches the granted request so the memory port sees stable address, data and strobes for the whole transaction.
- Routes the memory response back to the granted L1 only.

Parameters:
- ADDR_WIDTH, 16, line address width; matches lc3b_word.
- DATA_WIDTH, 128, line width; matches lc3b_data.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_write  in  1  I-cache line write request
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_wdata  in  DATA_WIDTH  I-cache write line
- i_pmem_resp  out  1  I-cache transaction done
- i_pmem_rdata  out  DATA_WIDTH  I-cache read line
- d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata  in  (same widths)  D-cache request
- d_pmem_resp, d_pmem_rdata  out  (same widths)  D-cache response
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory line address
- mem_wdata  out  DATA_WIDTH  memory write line
- mem_resp  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_WIDTH  memory read line, valid when mem_resp=1

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. State register, latched request (addr, wdata, read bit, write bit) and last_grant bit are all registered.
- Reset (async, any state):
  - State goes to IDLE.
  - mem_read, mem_write, i_pmem_resp and d_pmem_resp go to 0 immediately.
  - mem_address, mem_wdata and the latched request go to 0.
  - last_grant goes to 0, meaning I was last granted.
  - An in-flight transaction is abandoned; a late mem_resp arriving in IDLE is ignored.
- IDLE:
  - A requester is "active" if its read or write is 1.
  - If exactly one requester is active, grant it.
  - If both are active, arbitration follows the optional feature (default: D-cache wins).
  - At the grant edge: latch the requester's address, wdata and strobes; go to BUSY_I or BUSY_D; update last_grant.
  - If none is active, stay in IDLE.
- BUSY_x:
  - mem_read, mem_write, mem_address and mem_wdata are driven from the latched copy.
  - The first strobe appears in the cycle after the request is sampled (1-cycle grant latency).
  - Upstream changes during BUSY are ignored, including a requester dropping its request early.
  - On mem_resp=1: x_pmem_resp=1 combinationally in the same cycle and x_pmem_rdata=mem_rdata. The next state is IDLE.
  - The other requester's resp stays 0 and its rdata is undefined-but-stable.
  - In BUSY_x, i_pmem_rdata/d_pmem_rdata pass mem_rdata through at all times; only resp is gated.
- Turnaround: after a resp in cycle M, the earliest next memory strobe is at M+2. The IDLE cycle at M+1 re-samples requests, so a requester that deasserts after its resp is never re-granted.
- Read and write asserted together by one requester is illegal. The arbiter latches write=1, read=0 (write wins) and proceeds.
- Outside BUSY, mem_read=mem_write=0 and both upstream resp signals are 0.
- Memory-side protocol: strobes are held until mem_resp; no back-to-back strobes without an IDLE gap.

Optional Feature:
- Macro: L1_ARB_ROUND_ROBIN_EN.
- Defined: on contention in IDLE, grant the requester that is NOT last_grant (alternating).
- Undefined: fixed priority, D-cache always wins on contention.
- last_grant is maintained in both builds; only the contention decision differs.

Test Plan:
- Single I read: i_pmem_read=1, addr 0x1230 at cycle 0; mem_resp at cycle 4 with rdata 0xA5..A5 -> mem_read=1, mem_address=0x1230 in cycles 1-4; i_pmem_resp=1 with rdata 0xA5..A5 in cycle 4 only; d_pmem_resp=0 throughout.
- D write-back: d_pmem_write=1, addr 0x4F80, wdata 0xDEAD...BEEF -> mem_write=1 with that addr/data until resp; d_pmem_resp pulses once.
- Contention, default build: I read 0x0010 and D read 0x8000 in the same cycle -> D served first (mem_address=0x8000). I is granted in the IDLE cycle after D's resp and its strobe appears 2 cycles after D's resp.
- Contention with L1_ARB_ROUND_ROBIN_EN: three consecutive contended rounds after reset -> grant order D, I, D (last_grant resets to I).
- Early drop: d_pmem_read dropped 1 cycle after grant -> mem_read stays 1 with the latched address until mem_resp; the arbiter then returns to IDLE.
- Mid-transaction reset: reset pulsed during BUSY_I -> mem_read=0 in the same cycle; state is IDLE; a subsequent stray mem_resp produces no upstream resp.

Source files
------------

// File: rtl/l1_pmem_arbiter_if.sv
// Line-granular physical memory port: one requester (master) and one memory
// side (slave). The L1s and the shared memory port all use this bundle.
interface l1_pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output read, write, address, wdata, input resp, rdata);
    modport slave  (input read, write, address, wdata, output resp, rdata);
endinterface

// File: rtl/l1_pmem_arbiter.sv
// Serialises I-cache and D-cache line fills/write-backs onto one memory port.
// Define L1_ARB_ROUND_ROBIN_EN for alternating grants on contention (default: D wins).
//
// state  | meaning
// IDLE   | no transaction; sample both L1 requests, grant one
// BUSY_I | I-cache request latched and presented to memory, waiting mem resp
// BUSY_D | D-cache request latched and presented to memory, waiting mem resp
module l1_pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    l1_pmem_arbiter_if.slave    i_pmem,
    l1_pmem_arbiter_if.slave    d_pmem,
    l1_pmem_arbiter_if.master   mem
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  last_d_q, last_d_d;   // 1: D-cache was granted last

    logic i_act, d_act, pick_d, busy;

    assign i_act = i_pmem.read | i_pmem.write;
    assign d_act = d_pmem.read | d_pmem.write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        last_d_d = last_d_q;
        pick_d   = d_act;
        if (i_act && d_act) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
            pick_d = ~last_d_q;
`else
            pick_d = 1'b1;
`endif
        end
        case (state_q)
            IDLE: begin
                if (i_act || d_act) begin
                    last_d_d = pick_d;
                    // An illegal read+write request is latched as a write.
                    if (pick_d) begin
                        state_d = BUSY_D;
                        addr_d  = d_pmem.address;
                        wdata_d = d_pmem.wdata;
                        wr_d    = d_pmem.write;
                        rd_d    = d_pmem.read & ~d_pmem.write;
                    end else begin
                        state_d = BUSY_I;
                        addr_d  = i_pmem.address;
                        wdata_d = i_pmem.wdata;
                        wr_d    = i_pmem.write;
                        rd_d    = i_pmem.read & ~i_pmem.write;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem.resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem.read    = busy & rd_q;
    assign mem.write   = busy & wr_q;
    assign mem.address = addr_q;
    assign mem.wdata   = wdata_q;

    assign i_pmem.resp  = (state_q == BUSY_I) & mem.resp;
    assign d_pmem.resp  = (state_q == BUSY_D) & mem.resp;
    assign i_pmem.rdata = mem.rdata;
    assign d_pmem.rdata = mem.rdata;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Randomised and directed checks of l1_pmem_arbiter against a transaction-level
// model of who owns the memory port and what request was captured.
module tb_l1_pmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_pmem_arbiter_if i_if ();
    l1_pmem_arbiter_if d_if ();
    l1_pmem_arbiter_if m_if ();

    l1_pmem_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .i_pmem (i_if),
        .d_pmem (d_if),
        .mem    (m_if)
    );

    logic         ir, iw, dr, dw, mresp;
    logic [15:0]  ia, da;
    logic [127:0] iwd, dwd, mrd;

    assign i_if.read    = ir;
    assign i_if.write   = iw;
    assign i_if.address = ia;
    assign i_if.wdata   = iwd;
    assign d_if.read    = dr;
    assign d_if.write   = dw;
    assign d_if.address = da;
    assign d_if.wdata   = dwd;
    assign m_if.resp    = mresp;
    assign m_if.rdata   = mrd;

    int vectors = 0;
    int miscompares = 0;

    // Reference: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
    int           m_own;
    logic [15:0]  m_addr;
    logic [127:0] m_data;
    logic         m_rd, m_wr, m_last_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_addr = '0; m_data = '0; m_rd = 1'b0; m_wr = 1'b0; m_last_d = 1'b0;
    endtask

    task automatic clear_inputs();
        ir = 0; iw = 0; dr = 0; dw = 0; mresp = 0;
        ia = '0; da = '0; iwd = '0; dwd = '0; mrd = '0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic tick();
        bit busy, want_i, want_d, take_d;
        if (reset) model_reset();
        #1;
        busy = (m_own != 0);
        chk("mem_read",  m_if.read,  busy && m_rd);
        chk("mem_write", m_if.write, busy && m_wr);
        chk("i_resp", i_if.resp, (m_own == 1) && mresp);
        chk("d_resp", d_if.resp, (m_own == 2) && mresp);
        if (busy) begin
            chk("mem_address", m_if.address, m_addr);
            chk("mem_wdata",   m_if.wdata,   m_data);
            chk("i_rdata", i_if.rdata, mrd);
            chk("d_rdata", d_if.rdata, mrd);
        end
        @(posedge clk);
        if (!reset) begin
            if (busy) begin
                if (mresp) m_own = 0;
            end else begin
                want_i = ir || iw;
                want_d = dr || dw;
                if (want_i || want_d) begin
                    take_d = want_d;
                    if (want_i && want_d) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
                        take_d = !m_last_d;
`else
                        take_d = 1'b1;
`endif
                    end
                    m_own    = take_d ? 2 : 1;
                    m_last_d = take_d;
                    m_addr   = take_d ? da : ia;
                    m_data   = take_d ? dwd : iwd;
                    m_wr     = take_d ? dw : iw;
                    m_rd     = (take_d ? dr : ir) && !m_wr;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_req(inout logic rd, inout logic wr, inout logic [15:0] a,
                            inout logic [127:0] wd);
        int op;
        if (rd || wr) begin
            if ($urandom % 40 == 0) begin rd = 0; wr = 0; end
            else if ($urandom % 8 == 0) a = 16'($urandom);
        end else if ($urandom % 3 == 0) begin
            op = int'($urandom % 9);
            rd = (op <= 4);
            wr = (op >= 4);
            a  = 16'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    initial begin
        bit i_done, d_done;
        logic [15:0] exp_a;

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        tick();
        chk("rst_mem_address", m_if.address, 16'h0000);
        chk("rst_mem_wdata",   m_if.wdata,   128'h0);
        reset = 1'b0;
        tick();

        // Single I read, memory answers in cycle 4.
        ir = 1; ia = 16'h1230;
        for (int c = 0; c < 4; c++) tick();
        mresp = 1; mrd = {16{8'hA5}};
        chk("iread_strobe", m_if.read, 1'b1);
        tick();
        clear_inputs(); tick(); tick();

        // D write-back.
        dw = 1; da = 16'h4F80; dwd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        tick();
        chk("dwb_addr", m_if.address, 16'h4F80);
        tick(); tick();
        mresp = 1; mrd = '1;
        tick();
        clear_inputs(); tick();

        // Early drop: D read removed right after the grant.
        dr = 1; da = 16'h0ABC;
        tick();
        dr = 0; da = 16'hFFFF;
        tick(); tick(); tick();
        mresp = 1; mrd = 128'h1234;
        tick();
        mresp = 0; tick();

        // Reset pulsed while I read is in flight, then a stray response.
        ir = 1; ia = 16'h7777;
        tick(); tick();
        reset = 1'b1; tick();
        reset = 1'b0; clear_inputs();
        mresp = 1; mrd = 128'h55;
        tick();
        mresp = 0; tick();

        // Contention rounds from a fresh reset (last grant = I).
        reset = 1'b1; tick(); reset = 1'b0;
        ir = 1; ia = 16'h0010; dr = 1; da = 16'h8000;
        for (int r = 0; r < 3; r++) begin
            tick();
`ifdef L1_ARB_ROUND_ROBIN_EN
            exp_a = (r % 2 == 0) ? 16'h8000 : 16'h0010;
`else
            exp_a = 16'h8000;
`endif
            chk("contention_grant", m_if.address, exp_a);
            tick();
            mresp = 1; mrd = {4{$urandom}};
            tick();
            mresp = 0;
        end
        // D drops after its turn; I must be granted next.
        dr = 0; tick();
        chk("contention_i_next", m_if.address, 16'h0010);
        clear_inputs(); mresp = 1; tick(); mresp = 0; tick();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom % 400 == 0);
            mresp = (m_own != 0) ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
            mrd   = {$urandom, $urandom, $urandom, $urandom};
            rand_req(ir, iw, ia, iwd);
            rand_req(dr, dw, da, dwd);
            i_done = (m_own == 1) && mresp && !reset;
            d_done = (m_own == 2) && mresp && !reset;
            tick();
            if (i_done) begin ir = 0; iw = 0; end
            if (d_done) begin dr = 0; dw = 0; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
